// File: rtl/ex_mem_loader_pkg.sv
// Shared types and default sizing for the memory loader block.
// The FSM walks IDLE -> ARMED -> WRITE... -> DONE once per load session.
package ex_mem_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_LANES  = 2;
  localparam int DEF_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } target_e;

  // Width of a lane index; a single-lane build still needs a 1-bit counter.
  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ex_mem_loader_if.sv
// Beat input channel of the loader: the source (master) offers beats, the loader (slave) takes them.
interface ex_mem_loader_if
  import ex_mem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES
);
  // A beat transfers on a clk edge where in_valid and in_ready are both high; the source
  // holds its fields stable while in_valid waits, and in_ready may depend on state only.
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_target;
  logic                    in_auto_inc;
  logic [ADDR_W-1:0]       in_addr;
  logic [LANES*DATA_W-1:0] in_data;

  modport master (
    output in_valid, in_target, in_auto_inc, in_addr, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_target, in_auto_inc, in_addr, in_data,
    output in_ready
  );
endinterface

// File: rtl/ex_mem_loader_lane_serializer.sv
// Holds one accepted beat and presents its lanes one per cycle, lowest lane first.
module lane_serializer
  import ex_mem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  localparam int IDX_W = idx_w(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [DATA_W-1:0]       lane_data,
  output logic [IDX_W-1:0]        lane_idx,
  output logic                    last
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [LANES*DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = in_data;
      idx_d   = '0;
    end else if (step) begin
      shreg_d = shreg_q >> DATA_W;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign lane_data = shreg_q[DATA_W-1:0];
  assign lane_idx  = idx_q;
  assign last      = (idx_q == LAST_IDX);
endmodule

// File: rtl/ex_mem_loader.sv
// Boot/debug loader: holds the core while multi-lane beats are unpacked into single-word
// writes to the instruction or data memory, one strobe per cycle.
module ex_mem_loader
  import ex_mem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  ex_mem_loader_if.slave     beat,
  output logic               imem_we,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    word_count,
  output logic               err_overflow,
  output state_e             state_dbg
);
  localparam int PW    = ADDR_W + 1;
  localparam int LW    = ADDR_W + 2;
  localparam int IDX_W = idx_w(LANES);

  state_e            state_q, state_d;
  target_e           tgt_q, tgt_d;
  logic [PW-1:0]     ptr_q, ptr_d, base_q, base_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              load_en_q;

  logic              accept, lane_last, in_range, strobe;
  logic [IDX_W-1:0]  lane_idx;
  logic [DATA_W-1:0] lane_data;
  logic [LW-1:0]     lane_addr;

  assign beat.in_ready = load_en &&
                         ((state_q == ARMED) || ((state_q == WRITE) && lane_last));
  assign accept    = beat.in_valid && beat.in_ready;
  assign lane_addr = LW'(base_q) + LW'(lane_idx);
  assign in_range  = (lane_addr < LW'(DEPTH));
  assign strobe    = (state_q == WRITE) && in_range;

  lane_serializer #(.DATA_W(DATA_W), .LANES(LANES)) u_lane_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      ((state_q == WRITE) && !lane_last),
    .in_data   (beat.in_data),
    .lane_data (lane_data),
    .lane_idx  (lane_idx),
    .last      (lane_last)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (state_q == WRITE) begin
      if (in_range) cnt_d = cnt_q + (ADDR_W+1)'(1);
      else          ovf_d = 1'b1;
    end

    if (accept) begin
      tgt_d  = target_e'(beat.in_target);
      base_d = beat.in_auto_inc ? ptr_q : PW'(beat.in_addr);
      // Once past DEPTH the pointer parks there, so later lanes flag overflow instead of wrapping.
      if (beat.in_auto_inc && (ptr_q < PW'(DEPTH))) ptr_d = ptr_q + PW'(LANES);
    end

    unique case (state_q)
      IDLE: begin
        if (load_en && !load_en_q) begin
          state_d = ARMED;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (!load_en)    state_d = DONE;
        else if (accept) state_d = WRITE;
      end
      WRITE: begin
        if (lane_last) begin
          if (accept)        state_d = WRITE;
          else if (!load_en) state_d = DONE;
          else               state_d = ARMED;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // load_en_q resets high so a level already high at release is not taken as a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_q     <= TGT_IMEM;
      ptr_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      load_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      load_en_q <= load_en;
    end
  end

  assign imem_we      = strobe && (tgt_q == TGT_IMEM);
  assign dmem_we      = strobe && (tgt_q == TGT_DMEM);
  assign mem_addr     = (state_q == WRITE) ? lane_addr[ADDR_W-1:0] : '0;
  assign mem_wdata    = (state_q == WRITE) ? lane_data : '0;
  assign core_hold    = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign word_count   = cnt_q;
  assign err_overflow = ovf_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_ex_mem_loader.sv
// Directed bench for ex_mem_loader: scripted sessions, write scoreboard, one summary line.
module tb_ex_mem_loader;
  import ex_mem_loader_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int LANES  = 2;
  localparam int DEPTH  = 512;
  localparam int WR_W   = 1 + ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic              imem_we, dmem_we, core_hold, busy, done, err_overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   word_count;
  state_e            state_dbg;

  ex_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  ex_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .beat         (bus.slave),
    .imem_we      (imem_we),
    .dmem_we      (dmem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .err_overflow (err_overflow),
    .state_dbg    (state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [WR_W-1:0] exp_q[$];
  int wr_cyc[$];
  int acc_cyc[$];
  logic [WR_W-1:0] mon_got;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [WR_W-1:0] wr(input logic tgt, input logic [ADDR_W-1:0] a,
                                         input logic [DATA_W-1:0] d);
    return {tgt, a, d};
  endfunction

  // every strobe must match the next expected write, in order
  always @(negedge clk) begin
    if (imem_we || dmem_we) begin
      check("we_exclusive", {63'd0, imem_we & dmem_we}, 64'd0);
      check("we_in_write", {62'd0, state_dbg}, {62'd0, WRITE});
      mon_got = {dmem_we, mem_addr, mem_wdata};
      wr_cyc.push_back(cyc);
      check("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) check("wr_data", {22'd0, mon_got}, {22'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic start_session();
    @(posedge clk); #1;
    load_en = 1'b1;
    @(posedge clk); #1;
    check("sess_state", {62'd0, state_dbg}, {62'd0, ARMED});
    check("sess_ready", {63'd0, bus.in_ready}, 64'd1);
    check("sess_hold", {62'd0, core_hold, busy}, 64'd3);
    check("sess_count", {54'd0, word_count}, 64'd0);
    check("sess_ovf", {63'd0, err_overflow}, 64'd0);
  endtask

  task automatic send_beat(input logic tgt, input logic auto_inc, input logic [ADDR_W-1:0] addr,
                           input logic [LANES*DATA_W-1:0] data);
    int waited = 0;
    bus.in_valid    = 1'b1;
    bus.in_target   = tgt;
    bus.in_auto_inc = auto_inc;
    bus.in_addr     = addr;
    bus.in_data     = data;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_wait", {63'd0, waited < 20}, 64'd1);
    @(posedge clk); #1;
    acc_cyc.push_back(cyc);
    bus.in_valid = 1'b0;
  endtask

  task automatic end_session();
    int n_done = 0;
    load_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("done_pulses", n_done, 64'd1);
    check("end_hold", {62'd0, core_hold, busy}, 64'd0);
    check("end_state", {62'd0, state_dbg}, {62'd0, IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_target = 1'b0; bus.in_auto_inc = 1'b0;
    bus.in_addr = '0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {54'd0, bus.in_ready, imem_we, dmem_we, core_hold, busy, done,
                       err_overflow, word_count == 0, mem_addr == 0, mem_wdata == 0},
          {54'd0, 10'b0000000111});
    check("rst_state", {62'd0, state_dbg}, {62'd0, IDLE});
    reset = 1'b0;

    // imem, auto-inc from pointer 0; lane 0 is the low word
    start_session();
    exp_q.push_back(wr(1'b0, 9'd0, 32'h00100393));
    exp_q.push_back(wr(1'b0, 9'd1, 32'h00038303));
    send_beat(1'b0, 1'b1, 9'h155, {32'h00038303, 32'h00100393});
    repeat (2) @(posedge clk); #1;
    check("s1_count", {54'd0, word_count}, 64'd2);
    check("s1_drained", exp_q.size(), 64'd0);
    end_session();

    // dmem at explicit address
    start_session();
    exp_q.push_back(wr(1'b1, 9'h010, 32'h00008F00));
    exp_q.push_back(wr(1'b1, 9'h011, 32'h000000FF));
    send_beat(1'b1, 1'b0, 9'h010, {32'h000000FF, 32'h00008F00});
    repeat (2) @(posedge clk); #1;
    check("s2_count", {54'd0, word_count}, 64'd2);
    check("s2_drained", exp_q.size(), 64'd0);
    end_session();

    // three back-to-back auto-inc beats
    start_session();
    wr_cyc.delete(); acc_cyc.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(wr(1'b0, 9'(i), 32'h1000_0000 + i));
    for (int k = 0; k < 3; k++)
      send_beat(1'b0, 1'b1, 9'h1AA, {32'h1000_0000 + 2*k + 1, 32'h1000_0000 + 2*k});
    repeat (3) @(posedge clk); #1;
    check("s3_count", {54'd0, word_count}, 64'd6);
    check("s3_nwr", wr_cyc.size(), 64'd6);
    check("s3_nacc", acc_cyc.size(), 64'd3);
    if (wr_cyc.size() == 6 && acc_cyc.size() == 3) begin
      for (int i = 0; i < 6; i++) check("s3_wr_cycle", wr_cyc[i], acc_cyc[0] + i);
      for (int k = 1; k < 3; k++) check("s3_acc_cycle", acc_cyc[k], acc_cyc[0] + 2*k);
    end
    check("s3_drained", exp_q.size(), 64'd0);
    end_session();

    // top-of-memory beat: lane 1 lands at 512 and is dropped
    start_session();
    exp_q.push_back(wr(1'b0, 9'd511, 32'hCAFE0001));
    send_beat(1'b0, 1'b0, 9'd511, {32'hCAFE0002, 32'hCAFE0001});
    repeat (3) @(posedge clk); #1;
    check("s4_ovf", {63'd0, err_overflow}, 64'd1);
    check("s4_count", {54'd0, word_count}, 64'd1);
    check("s4_drained", exp_q.size(), 64'd0);
    end_session();
    check("s4_ovf_sticky", {63'd0, err_overflow}, 64'd1);

    // load_en falls during lane 0; lane 1 still written (start_session checks ovf cleared)
    start_session();
    exp_q.push_back(wr(1'b0, 9'd0, 32'hA0A0A0A0));
    exp_q.push_back(wr(1'b0, 9'd1, 32'hB1B1B1B1));
    send_beat(1'b0, 1'b1, 9'd0, {32'hB1B1B1B1, 32'hA0A0A0A0});
    end_session();
    check("s5_drained", exp_q.size(), 64'd0);
    check("s5_count", {54'd0, word_count}, 64'd2);

    // re-rise of load_en while in DONE is ignored
    start_session();
    load_en = 1'b0;
    @(posedge clk); #1;
    check("s6_done_state", {62'd0, state_dbg}, {62'd0, DONE});
    load_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("s6_no_rearm", {62'd0, state_dbg}, {62'd0, IDLE});
    check("s6_no_hold", {63'd0, core_hold}, 64'd0);
    load_en = 1'b0;

    // reset between lane 0 and lane 1
    start_session();
    exp_q.push_back(wr(1'b0, 9'd0, 32'h11111111));
    send_beat(1'b0, 1'b1, 9'd0, {32'h22222222, 32'h11111111});
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("s7_rst_outs", {54'd0, bus.in_ready, imem_we, dmem_we, core_hold, busy, done,
                          err_overflow, word_count == 0, mem_addr == 0, mem_wdata == 0},
          {54'd0, 10'b0000000111});
    check("s7_rst_state", {62'd0, state_dbg}, {62'd0, IDLE});
    @(posedge clk); #1;
    reset = 1'b0;
    // load_en still high across release: not a rising edge
    repeat (3) @(posedge clk); #1;
    check("s7_no_session", {62'd0, state_dbg}, {62'd0, IDLE});
    check("s7_drained", exp_q.size(), 64'd0);
    load_en = 1'b0;
    start_session();
    end_session();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_loader.md
EX_MEM_LOADER -- requirements
Module: ex_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, 9, word-address width.
REQ-003 SHALL have parameter LANES, 2, words carried per input beat (1..8).
REQ-004 SHALL have parameter DEPTH, 512, words per target memory (DEPTH <= 2**ADDR_W).
REQ-005 SHALL have one clock, named clk, and one reset, named reset, which is asynchronous and active-high: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port load_en  in  1  load session enable, level.
REQ-007 SHALL have port in_valid  in  1  input beat valid.
REQ-008 SHALL have port in_ready  out  1  beat accepted when in_valid and in_ready are both high at the clk edge.
REQ-009 SHALL have port in_target  in  1  0 = instruction memory, 1 = data memory.
REQ-010 SHALL have port in_auto_inc  in  1  1 = use the internal pointer, 0 = use in_addr.
REQ-011 SHALL have port in_addr  in  ADDR_W  base word address of the beat.
REQ-012 SHALL have port in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have ports imem_we and dmem_we  out  1 each  one-cycle write strobes.
REQ-014 SHALL have ports mem_addr  out  ADDR_W and mem_wdata  out  DATA_W, shared by both memories.
REQ-015 SHALL have ports core_hold  out  1 (holds the core pipeline) and busy  out  1.
REQ-016 SHALL have ports done  out  1 (one-cycle end-of-session pulse), word_count  out  ADDR_W+1 (words written this session) and err_overflow  out  1 (sticky).

Function
REQ-017 SHALL use FSM states IDLE, ARMED, WRITE and DONE.
REQ-018 SHALL move IDLE->ARMED on a load_en rising edge, clearing word_count, err_overflow and the internal pointer to 0.
REQ-019 SHALL assert in_ready in ARMED while load_en=1, and in WRITE only on the last-lane cycle while load_en=1.
REQ-020 SHALL, on beat acceptance, latch data, target and base (pointer if in_auto_inc=1, else in_addr) and enter or stay in WRITE.
REQ-021 SHALL write lane i at base+i in cycle N+1+i for a beat accepted at edge N: one strobe per cycle, lanes in ascending order.
REQ-022 SHALL sustain back-to-back beats at one beat per LANES cycles.
REQ-023 SHALL advance the internal pointer by LANES per accepted auto-inc beat, with no wrap.
REQ-024 SHALL, for a lane address >= DEPTH, suppress that strobe, set err_overflow and not count the word.
REQ-025 SHALL increment word_count once per issued strobe.
REQ-026 SHALL, on load_en falling in WRITE, finish the current beat and then enter DONE; on load_en falling in ARMED, enter DONE on the next edge.
REQ-027 SHALL assert done for exactly one cycle in DONE, then go DONE->IDLE.
REQ-028 SHALL hold core_hold=1 and busy=1 in ARMED, WRITE and DONE, and 0 in IDLE.
REQ-029 SHALL hold imem_we=dmem_we=0 outside WRITE, with never both high in the same cycle.
REQ-030 SHALL ignore a load_en re-rise during DONE; a new session requires a fresh rising edge observed in IDLE.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-beat, immediately force IDLE and drive all outputs to 0 (in_ready, strobes, mem_addr, mem_wdata, core_hold, busy, done, word_count, err_overflow), discarding a partial beat.
REQ-032 SHALL, after reset release, detect a load_en rising edge only from the sampled low-to-high transition.

Structure
REQ-033 SHALL place the state enum, the target enum (TGT_IMEM, TGT_DMEM) and default parameter constants in package ex_mem_loader_pkg.
REQ-034 SHALL implement lane shifting and lane index in sub-module lane_serializer (parameters DATA_W, LANES).

Verification
REQ-035 Scenario: LANES=2, load_en rise, one beat target=0 auto_inc=1 data {0x00038303, 0x00100393} -> imem_we at addr 0 with 0x00100393, then addr 1 with 0x00038303, word_count=2.
REQ-036 Scenario: target=1, in_addr=0x010, data {0x000000FF, 0x00008F00} -> dmem_we at 0x010 and 0x011 only, imem_we stays 0.
REQ-037 Scenario: three back-to-back auto-inc beats -> strobes on six consecutive cycles at addresses 0..5, in_ready high every second cycle.
REQ-038 Scenario: in_addr=511 with LANES=2 -> write at 511 only, err_overflow=1, word_count=1.
REQ-039 Scenario: load_en drops mid-beat -> remaining lane still written, done pulses once, then core_hold=0.
REQ-040 Scenario: reset asserted between lane 0 and lane 1 -> lane 1 never strobed, all outputs 0 in the same cycle.
